// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous single-port data RAM between two execution
//   pipelines and a burst loader. In ARB the two pipelines are arbitrated
//   round-robin; a loader burst switches the port to LOAD until the
//   programmed number of words has been written.
// Ports
//   clk, rst                      clock, async active-low reset
//   req_i/we_i/kill_i [1:0]       per-pipeline request, store flag, squash
//   addr{0,1}_i, wdata{0,1}_i     per-pipeline address / store data
//   gnt_o [1:0]                   combinational one-hot-or-zero grant
//   rvalid_o [1:0], rdata_o       load return (valid registered, data from RAM)
//   ld_start_i/ld_base_i/ld_len_i loader burst setup
//   ld_valid_i/ld_data_i/ld_ready_o  loader word handshake
//   ld_done_o                     one-cycle burst-complete pulse
//   mem_addr_o/mem_wdata_o/mem_write_o/mem_rdata_i  RAM port
module mem_port_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic [1:0]        kill_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              ld_start_i,
  input  logic [ADDR_W-1:0] ld_base_i,
  input  logic [ADDR_W-1:0] ld_len_i,
  input  logic              ld_valid_i,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              ld_ready_o,
  output logic              ld_done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic {ARB, LOAD} state_e;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;       // 1: pipeline 1 wins a tie
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic              done_q, done_d;
  logic              gsel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB;
      rr_q     <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    rvalid_d    = '0;
    done_d      = 1'b0;
    gnt_o       = '0;
    gsel        = 1'b0;
    ld_ready_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = addr0_i;
    mem_wdata_o = wdata0_i;
    // Combinational outputs are gated by rst so nothing reaches the RAM
    // while reset is held, even if requesters keep driving.
    if (rst) begin
      unique case (state_q)
        ARB: begin
          unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = rr_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
          endcase
          gsel = gnt_o[1];
          if (gsel) begin
            mem_addr_o  = addr1_i;
            mem_wdata_o = wdata1_i;
          end
          // A killed access still consumes its grant and moves the pointer;
          // only its side effects (write, load return) are dropped.
          if (gnt_o != 2'b00) begin
            mem_write_o    = we_i[gsel] & ~kill_i[gsel];
            rvalid_d[gsel] = ~we_i[gsel] & ~kill_i[gsel];
            rr_d           = gnt_o[0];
          end
          if (ld_start_i) begin
            if (ld_len_i != '0) begin
              ptr_d   = ld_base_i;
              cnt_d   = ld_len_i;
              state_d = LOAD;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        LOAD: begin
          ld_ready_o  = 1'b1;
          mem_addr_o  = ptr_q;
          mem_wdata_o = ld_data_i;
          if (ld_valid_i) begin
            mem_write_o = 1'b1;
            ptr_d       = ptr_q + ADDR_W'(1);
            cnt_d       = cnt_q - ADDR_W'(1);
            if (cnt_q == ADDR_W'(1)) begin
              state_d = ARB;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  assign rvalid_o  = rvalid_q;
  assign ld_done_o = done_q;
  assign rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed stimulus pushes expected RAM writes,
// load returns and done pulses (tagged with the expected cycle) into queues;
// a negedge monitor pops and compares whenever the DUT shows one.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_i, we_i, kill_i, gnt_o, rvalid_o;
  logic [8:0]  addr0_i, addr1_i, ld_base_i, ld_len_i, mem_addr_o;
  logic [15:0] wdata0_i, wdata1_i, rdata_o, ld_data_i, mem_wdata_o, mem_rdata_i;
  logic        ld_start_i, ld_valid_i, ld_ready_o, ld_done_o, mem_write_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct { int cyc; logic [8:0] a; logic [15:0] d; } wr_t;
  typedef struct { int cyc; logic [1:0] v; logic [15:0] d; } rv_t;
  wr_t wq[$];
  rv_t rq[$];
  int  dq[$];

  logic [15:0] ram [512];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous RAM (read-before-write).
  initial foreach (ram[i]) ram[i] = 16'h0000;
  always @(posedge clk) begin
    if (mem_write_o) ram[mem_addr_o] <= mem_wdata_o;
    mem_rdata_i <= ram[mem_addr_o];
  end

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .kill_i(kill_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .ld_start_i(ld_start_i), .ld_base_i(ld_base_i), .ld_len_i(ld_len_i),
    .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i), .ld_ready_o(ld_ready_o),
    .ld_done_o(ld_done_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_write_o(mem_write_o), .mem_rdata_i(mem_rdata_i)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexp(input string nm);
    total++;
    bad++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  function automatic void exp_wr(input logic [8:0] a, input logic [15:0] d);
    wr_t e;
    e.cyc = cyc; e.a = a; e.d = d;
    wq.push_back(e);
  endfunction

  function automatic void exp_rv(input logic [1:0] v, input logic [15:0] d);
    rv_t e;
    e.cyc = cyc + 1; e.v = v; e.d = d;
    rq.push_back(e);
  endfunction

  function automatic void exp_done();
    dq.push_back(cyc + 1);
  endfunction

  // Monitor: every DUT output event must match the head of its queue.
  always @(negedge clk) begin
    if (mem_write_o === 1'b1) begin
      if (wq.size() == 0) unexp("wr_extra");
      else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_cyc", cyc, e.cyc);
        chk("wr_addr", mem_addr_o, e.a);
        chk("wr_data", mem_wdata_o, e.d);
      end
    end
    if (rvalid_o !== 2'b00) begin
      if (rq.size() == 0) unexp("rvalid_extra");
      else begin
        rv_t e;
        e = rq.pop_front();
        chk("rv_cyc", cyc, e.cyc);
        chk("rv_vec", rvalid_o, e.v);
        chk("rv_data", rdata_o, e.d);
      end
    end
    if (ld_done_o !== 1'b0) begin
      if (dq.size() == 0) unexp("done_extra");
      else chk("done_cyc", cyc, dq.pop_front());
    end
  end

  // Advance to just after the next rising edge and drive pipeline inputs.
  task automatic step(input logic [1:0] req, input logic [1:0] we, input logic [1:0] kill,
                      input logic [8:0] a0, input logic [8:0] a1,
                      input logic [15:0] d0, input logic [15:0] d1);
    @(posedge clk); #1;
    req_i = req; we_i = we; kill_i = kill;
    addr0_i = a0; addr1_i = a1; wdata0_i = d0; wdata1_i = d1;
  endtask

  task automatic chk_gnt(input logic [1:0] eg);
    @(negedge clk);
    chk("gnt", gnt_o, eg);
  endtask

  logic [1:0] g39 [4];

  initial begin
    g39 = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst = 1'b0;
    req_i = 2'b11; we_i = 2'b11; kill_i = 2'b00;
    addr0_i = 9'h001; addr1_i = 9'h002; wdata0_i = 16'h1; wdata1_i = 16'h2;
    ld_start_i = 1'b0; ld_base_i = '0; ld_len_i = '0; ld_valid_i = 1'b1; ld_data_i = 16'hFFFF;

    // Reset: combinational outputs gated, registered outputs cleared.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_wr", mem_write_o, 1'b0);
    chk("rst_ldrdy", ld_ready_o, 1'b0);
    chk("rst_rvalid", rvalid_o, 2'b00);
    chk("rst_done", ld_done_o, 1'b0);

    step(2'b00, 2'b00, 2'b00, 9'h0, 9'h0, 16'h0, 16'h0);
    rst = 1'b1; ld_valid_i = 1'b0;
    chk_gnt(2'b00);

    // Both pipelines store every cycle: strict alternation starting at 0.
    for (int k = 0; k < 4; k++) begin
      step(2'b11, 2'b11, 2'b00, 9'h001 + 9'(k), 9'h101 + 9'(k), 16'h1000 + 16'(k), 16'h2000 + 16'(k));
      if (k % 2 == 0) exp_wr(9'h001 + 9'(k), 16'h1000 + 16'(k));
      else            exp_wr(9'h101 + 9'(k), 16'h2000 + 16'(k));
      chk_gnt(g39[k]);
    end

    // p1 stores BEEF, then loads it back.
    step(2'b10, 2'b10, 2'b00, 9'h0, 9'h055, 16'h0, 16'hBEEF); exp_wr(9'h055, 16'hBEEF); chk_gnt(2'b10);
    step(2'b10, 2'b00, 2'b00, 9'h0, 9'h055, 16'h0, 16'h0);    exp_rv(2'b10, 16'hBEEF);  chk_gnt(2'b10);
    // Tie favours p0; kill on the losing p1 is ignored.
    step(2'b11, 2'b11, 2'b10, 9'h010, 9'h020, 16'h1234, 16'h5555); exp_wr(9'h010, 16'h1234); chk_gnt(2'b01);
    // Killed load on p1: granted, no rvalid, pointer moves to favour p0.
    step(2'b10, 2'b00, 2'b10, 9'h0, 9'h055, 16'h0, 16'h0); chk_gnt(2'b10);
    // Killed store on p0 wins the tie: no RAM write.
    step(2'b11, 2'b11, 2'b01, 9'h010, 9'h020, 16'h9999, 16'h5555); chk_gnt(2'b01);
    chk("kill_wr", mem_write_o, 1'b0);
    // Tie now favours p1 (killed grant still moved the pointer).
    step(2'b11, 2'b00, 2'b00, 9'h010, 9'h055, 16'h0, 16'h0); exp_rv(2'b10, 16'hBEEF); chk_gnt(2'b10);
    // Address 0x010 still holds 1234.
    step(2'b01, 2'b00, 2'b00, 9'h010, 9'h0, 16'h0, 16'h0);   exp_rv(2'b01, 16'h1234); chk_gnt(2'b01);
    step(2'b00, 2'b11, 2'b00, 9'h0, 9'h0, 16'h0, 16'h0); chk_gnt(2'b00);
    chk("idle_wr", mem_write_o, 1'b0);

    // Zero-length burst: stays in ARB, same-cycle store proceeds, done next cycle.
    step(2'b01, 2'b11, 2'b00, 9'h030, 9'h0, 16'h7777, 16'h0);
    ld_start_i = 1'b1; ld_base_i = 9'h0AA; ld_len_i = 9'd0;
    exp_wr(9'h030, 16'h7777); exp_done(); chk_gnt(2'b01);
    step(2'b00, 2'b00, 2'b00, 9'h0, 9'h0, 16'h0, 16'h0); ld_start_i = 1'b0;
    chk_gnt(2'b00);
    chk("len0_ldrdy", ld_ready_o, 1'b0);

    // Burst 0x1FE len 3 with a gap; ld_valid in ARB ignored; wraps to 0x000.
    step(2'b10, 2'b11, 2'b00, 9'h0, 9'h040, 16'h0, 16'hAAAA);
    ld_start_i = 1'b1; ld_base_i = 9'h1FE; ld_len_i = 9'd3; ld_valid_i = 1'b1; ld_data_i = 16'hDEAD;
    exp_wr(9'h040, 16'hAAAA); chk_gnt(2'b10);
    chk("arb_ldrdy", ld_ready_o, 1'b0);
    step(2'b11, 2'b11, 2'b00, 9'h050, 9'h060, 16'h1111, 16'h2222);
    ld_start_i = 1'b0; ld_data_i = 16'h0A01; exp_wr(9'h1FE, 16'h0A01); chk_gnt(2'b00);
    chk("load_ldrdy", ld_ready_o, 1'b1);
    step(2'b11, 2'b11, 2'b00, 9'h050, 9'h060, 16'h1111, 16'h2222);
    ld_valid_i = 1'b0; ld_start_i = 1'b1; ld_base_i = 9'h0AA; ld_len_i = 9'd5;
    chk_gnt(2'b00);
    chk("gap_wr", mem_write_o, 1'b0);
    step(2'b11, 2'b11, 2'b00, 9'h050, 9'h060, 16'h1111, 16'h2222);
    ld_start_i = 1'b0; ld_valid_i = 1'b1; ld_data_i = 16'h0A02; exp_wr(9'h1FF, 16'h0A02); chk_gnt(2'b00);
    step(2'b11, 2'b11, 2'b00, 9'h050, 9'h060, 16'h1111, 16'h2222);
    ld_data_i = 16'h0A03; exp_wr(9'h000, 16'h0A03); exp_done(); chk_gnt(2'b00);
    step(2'b11, 2'b11, 2'b00, 9'h050, 9'h060, 16'h1111, 16'h2222);
    ld_data_i = 16'hBAD0; exp_wr(9'h050, 16'h1111); chk_gnt(2'b01);
    chk("resume_ldrdy", ld_ready_o, 1'b0);
    step(2'b10, 2'b11, 2'b00, 9'h050, 9'h060, 16'h1111, 16'h2222);
    ld_valid_i = 1'b0; exp_wr(9'h060, 16'h2222); chk_gnt(2'b10);

    // Reset mid-burst: abandon without done, no further writes, pointer back to p0.
    step(2'b01, 2'b11, 2'b00, 9'h080, 9'h0, 16'h4444, 16'h0);
    ld_start_i = 1'b1; ld_base_i = 9'h100; ld_len_i = 9'd4;
    exp_wr(9'h080, 16'h4444); chk_gnt(2'b01);
    step(2'b11, 2'b11, 2'b00, 9'h070, 9'h071, 16'h3333, 16'h3334);
    ld_start_i = 1'b0; ld_valid_i = 1'b1; ld_data_i = 16'h0B01; exp_wr(9'h100, 16'h0B01); chk_gnt(2'b00);
    step(2'b11, 2'b11, 2'b00, 9'h070, 9'h071, 16'h3333, 16'h3334);
    ld_data_i = 16'h0B02; exp_wr(9'h101, 16'h0B02); chk_gnt(2'b00);
    step(2'b11, 2'b11, 2'b00, 9'h070, 9'h071, 16'h3333, 16'h3334);
    ld_data_i = 16'h0B03; rst = 1'b0;
    #1;
    chk("rstb_ldrdy", ld_ready_o, 1'b0);
    chk("rstb_wr", mem_write_o, 1'b0);
    chk_gnt(2'b00);
    step(2'b11, 2'b11, 2'b00, 9'h070, 9'h071, 16'h3333, 16'h3334);
    rst = 1'b1; exp_wr(9'h070, 16'h3333); chk_gnt(2'b01);
    chk("post_ldrdy", ld_ready_o, 1'b0);
    step(2'b00, 2'b00, 2'b00, 9'h0, 9'h0, 16'h0, 16'h0); ld_valid_i = 1'b0;
    chk_gnt(2'b00);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("wr_left", wq.size(), 0);
    chk("rv_left", rq.size(), 0);
    chk("done_left", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, data-memory address width.
REQ-002 Parameter DATA_W, default 16, data-memory word width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_i  input  2  per-pipeline access request; bit i belongs to pipeline i; held until granted.
REQ-006 we_i  input  2  per-pipeline access type: 1 = store (STR), 0 = load.
REQ-007 addr0_i, addr1_i  input  ADDR_W each  per-pipeline word address.
REQ-008 wdata0_i, wdata1_i  input  DATA_W each  per-pipeline store data.
REQ-009 kill_i  input  2  per-pipeline squash (delayed branch taken); suppresses that pipeline's granted access side effects.
REQ-010 gnt_o  output  2  one-hot-or-zero grant, combinational, same cycle as request.
REQ-011 rvalid_o  output  2  load data valid for pipeline i, registered.
REQ-012 rdata_o  output  DATA_W  load data, pass-through of mem_rdata_i.
REQ-013 ld_start_i  input  1  loader burst start pulse.
REQ-014 ld_base_i  input  ADDR_W  burst start address, sampled with ld_start_i.
REQ-015 ld_len_i  input  ADDR_W  burst word count, sampled with ld_start_i.
REQ-016 ld_valid_i / ld_data_i  input  1 / DATA_W  loader word handshake.
REQ-017 ld_ready_o  output  1  loader may transfer this cycle.
REQ-018 ld_done_o  output  1  one-cycle burst-complete pulse, registered.
REQ-019 mem_addr_o / mem_wdata_o / mem_write_o  output  ADDR_W / DATA_W / 1  RAM port, combinational.
REQ-020 mem_rdata_i  input  DATA_W  RAM synchronous read data, valid one cycle after address.

Function
REQ-021 FSM states SHALL be ARB and LOAD; at most one RAM access per cycle.
REQ-022 In ARB, a single requester SHALL be granted immediately; with both requesting, the pipeline not granted most recently SHALL win.
REQ-023 Round-robin pointer SHALL update only on a grant, to favour the non-granted pipeline next.
REQ-024 On grant to i: mem_addr_o = addr_i; mem_wdata_o = wdata_i; mem_write_o = we_i[i] AND NOT kill_i[i].
REQ-025 Granted load with kill_i[i]=0 SHALL raise rvalid_o[i] exactly one cycle later; killed load SHALL produce no rvalid.
REQ-026 A killed access SHALL still consume its grant (requester drops it); pointer updates normally.
REQ-027 kill_i on a non-granted pipeline SHALL have no effect on the arbiter.
REQ-028 No request in ARB: mem_write_o=0, gnt_o=0, mem_addr_o/mem_wdata_o don't-care.
REQ-029 ld_start_i in ARB with ld_len_i != 0 SHALL load address pointer = ld_base_i, counter = ld_len_i, enter LOAD next cycle; requests arriving the same cycle are still arbitrated normally.
REQ-030 ld_start_i with ld_len_i = 0 SHALL stay in ARB, perform no writes, pulse ld_done_o next cycle.
REQ-031 ld_start_i while in LOAD SHALL be ignored.
REQ-032 In LOAD: gnt_o=0, ld_ready_o=1; ld_valid_i=1 writes ld_data_i at pointer, pointer += 1 modulo 2^ADDR_W, counter -= 1.
REQ-033 ld_valid_i=0 in LOAD SHALL hold state, no write.
REQ-034 Write decrementing counter to 0 SHALL return FSM to ARB next cycle and pulse ld_done_o that cycle.
REQ-035 ld_ready_o SHALL be 0 in ARB; ld_valid_i in ARB ignored.

Reset
REQ-036 rst low SHALL asynchronously force: state ARB, pointer favours pipeline 0, counter 0, pointer address 0, rvalid_o=0, ld_done_o=0.
REQ-037 Reset mid-burst SHALL abandon the burst without ld_done_o; no further writes.
REQ-038 Combinational outputs during reset: gnt_o=0, mem_write_o=0, ld_ready_o=0.

Verification
REQ-039 Both pipelines store each cycle, 4 cycles after reset -> grants 01,10,01,10; four RAM writes in that order.
REQ-040 Pipeline 1 load addr 0x055, RAM holds 0xBEEF -> gnt_o=10, next cycle rvalid_o=10, rdata_o=0xBEEF.
REQ-041 Pipeline 0 store addr 0x010 with kill_i=01 same cycle -> gnt_o=01, mem_write_o=0, RAM unchanged.
REQ-042 ld_start base 0x1FE len 3, ld_valid with one-cycle gap -> writes 0x1FE,0x1FF,0x000; pipeline requests stalled; ld_done_o pulses once; ARB resumes.
REQ-043 ld_start len 0 -> no writes, ld_done_o pulse next cycle, gnt_o unaffected.
REQ-044 rst low after second burst word -> state ARB immediately, no ld_done_o, no further writes.
